// File: rtl/gpio_pattern_pkg.sv
// gpio_pattern_pkg: mode/state enums and the pattern function shared by the pattern generator.
package gpio_pattern_pkg;
  typedef enum logic [1:0] {MODE_BIN, MODE_GRAY, MODE_WALK, MODE_TOGGLE} mode_t;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  // Evaluated at 32 bits; callers truncate to their channel count.
  function automatic logic [31:0] pattern(input mode_t m, input logic [31:0] seq, input int unsigned nch);
    return m == MODE_BIN  ? seq :
           m == MODE_GRAY ? seq ^ (seq >> 1) :
           m == MODE_WALK ? 32'd1 << (seq % nch) :
                            {32{seq[0]}};
  endfunction
endpackage

// File: rtl/gpio_prescaler.sv
// gpio_prescaler: free-running step counter with enable, synchronous clear and terminal-count flag.
module gpio_prescaler #(
  parameter int LOG2DELAY = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);
  logic [LOG2DELAY-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + LOG2DELAY'(1);
  assign tc = &cnt;
endmodule

// File: rtl/gpio_pattern_gen.sv
// gpio_pattern_gen: armed GPIO/LED exercise-pattern generator (binary, Gray, walking-one, all-toggle).
// Define GPIO_PATTERN_SAFE_MASK_EN to AND the outputs with safe_mask captured at arm time.
module gpio_pattern_gen
  import gpio_pattern_pkg::*;
#(
  parameter int NCH       = 3,
  parameter int LOG2DELAY = 21
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           arm,
  input  logic [1:0]     mode,
  input  logic [NCH-1:0] safe_mask,
  output logic [NCH-1:0] out,
  output logic           step_strobe,
  output logic           running
);
  localparam logic [NCH-1:0] LAST = NCH'(NCH - 1);
  state_t state, state_next;
  mode_t mode_q;
  logic [NCH-1:0] seq, seq_next, p, mask;
  logic run_go, entry, step, tc;
  gpio_prescaler #(.LOG2DELAY(LOG2DELAY)) u_pre (
    .clk(clk),
    .rst(rst),
    .en (run_go),
    .clr(!run_go),
    .tc (tc)
  );
  assign p = NCH'(pattern(mode_q, 32'(seq), NCH));
  // Disarm wins over a coincident terminal count: step requires arm.
  always_comb begin
    state_next = arm ? ST_RUN : ST_IDLE;
    run_go = state == ST_RUN && arm;
    entry = state == ST_IDLE && arm;
    step = run_go && tc;
    seq_next = (mode_q == MODE_WALK && seq == LAST) ? '0 : seq + NCH'(1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      mode_q <= MODE_BIN;
      seq <= '0;
      out <= '0;
      step_strobe <= 1'b0;
      running <= 1'b0;
    end else begin
      state <= state_next;
      if (entry) mode_q <= mode_t'(mode);
      seq <= !run_go ? '0 : step ? seq_next : seq;
      out <= run_go ? p & mask : '0;
      step_strobe <= step;
      running <= run_go;
    end
`ifdef GPIO_PATTERN_SAFE_MASK_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) mask <= '0;
    else if (entry) mask <= safe_mask;
`else
  logic unused_mask;
  assign unused_mask = ^safe_mask;
  assign mask = '1;
`endif
endmodule
